// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 timing generator: slot count,
// slot-counter width and the init-state encoding.
package ym3438_pkg;

  localparam int CYCLE_COUNT = 24;
  localparam int CYCLE_W     = 5;

  localparam logic [CYCLE_W-1:0] CYCLE_LAST = CYCLE_W'(CYCLE_COUNT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    INIT  = 2'd1,
    DRAIN = 2'd2
  } init_state_e;

endpackage

// File: rtl/ym3438_presc.sv
// Phase generator: c1/c2 one-MCLK enables from an internal prescaler, or from
// edges of phi_ext when YM3438_CLK_EXT_EN is defined.
module ym3438_presc #(
  parameter int DIV = 6
) (
  input  logic MCLK,
  input  logic rst,
`ifdef YM3438_CLK_EXT_EN
  input  logic phi_ext,
`endif
  output logic c1,
  output logic c2
);

`ifdef YM3438_CLK_EXT_EN
  logic phi_s_q, phi_d_q;

  // Two stages give a clean one-MCLK latency from the phi_ext edge to the pulse.
  always_ff @(posedge MCLK) begin
    if (rst) begin
      phi_s_q <= 1'b0;
      phi_d_q <= 1'b0;
    end else begin
      phi_s_q <= phi_ext;
      phi_d_q <= phi_s_q;
    end
  end

  assign c1 = ~rst &  phi_s_q & ~phi_d_q;
  assign c2 = ~rst & ~phi_s_q &  phi_d_q;
`else
  localparam int PW = $clog2(DIV);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (presc_q == PW'(DIV - 1)) presc_d = '0;
  end

  always_ff @(posedge MCLK) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Gating with rst keeps a reset landing mid-phase from leaking a pulse.
  assign c1 = ~rst & (presc_q == '0);
  assign c2 = ~rst & (presc_q == PW'(DIV / 2));
`endif

endmodule

// File: rtl/ym3438_timing_gen.sv
// YM3438 master timing: phase enables, 24-slot cycle counter and init FSM.
// Define YM3438_CLK_EXT_EN to take phases from the phi_ext input instead.
module ym3438_timing_gen
  import ym3438_pkg::*;
#(
  parameter int DIV = 6
) (
  input  logic               MCLK,
  input  logic               rst,
  input  logic               ic,
`ifdef YM3438_CLK_EXT_EN
  input  logic               phi_ext,
`endif
  output logic               c1,
  output logic               c2,
  output logic [CYCLE_W-1:0] cycle,
  output logic               sync,
  output logic               ic_int
);

  init_state_e        state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;

  ym3438_presc #(.DIV(DIV)) u_presc (
    .MCLK    (MCLK),
    .rst     (rst),
`ifdef YM3438_CLK_EXT_EN
    .phi_ext (phi_ext),
`endif
    .c1      (c1),
    .c2      (c2)
  );

  // ic is only looked at on c1, so short pulses between c1s are ignored.
  always_comb begin
    state_d = state_q;
    if (c1) begin
      case (state_q)
        RUN:     if (ic) state_d = INIT;
        INIT:    if (!ic) state_d = DRAIN;
        DRAIN: begin
          if (ic)                         state_d = INIT;
          else if (cycle_q == CYCLE_LAST) state_d = RUN;
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    cycle_d = cycle_q;
    if (c2) begin
      if (state_q == INIT || cycle_q == CYCLE_LAST) cycle_d = '0;
      else                                          cycle_d = cycle_q + 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      state_q <= INIT;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  assign cycle  = cycle_q;
  assign sync   = (cycle_q == '0);
  assign ic_int = (state_q != RUN);

endmodule

// File: tb/tb_ym3438_timing_gen.sv
// Self-checking bench for ym3438_timing_gen (default prescaler build, DIV=6).
module tb_ym3438_timing_gen;

  localparam int DIV = 6;

  logic       MCLK = 1'b0;
  logic       rst  = 1'b1;
  logic       ic   = 1'b0;
  logic       c1, c2, sync, ic_int;
  logic [4:0] cycle;
`ifdef YM3438_CLK_EXT_EN
  logic       phi_ext = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  // Reference model state: prescaler, slot counter, init state (0 RUN, 1 INIT, 2 DRAIN)
  int m_presc = 0;
  int m_cycle = 0;
  int m_state = 1;

  ym3438_timing_gen #(.DIV(DIV)) dut (
    .MCLK    (MCLK),
    .rst     (rst),
    .ic      (ic),
`ifdef YM3438_CLK_EXT_EN
    .phi_ext (phi_ext),
`endif
    .c1      (c1),
    .c2      (c2),
    .cycle   (cycle),
    .sync    (sync),
    .ic_int  (ic_int)
  );

  // clock / reset block
  always #5 MCLK = ~MCLK;

  // scoreboard: compare DUT outputs against the expected entry for this cycle
  always @(negedge MCLK) begin
    logic [8:0] got, e;
    #2;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {c1, c2, cycle, sync, ic_int};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got c1=%b c2=%b cycle=%0d sync=%b ic_int=%b exp c1=%b c2=%b cycle=%0d sync=%b ic_int=%b",
                 $time, got[8], got[7], got[6:2], got[1], got[0], e[8], e[7], e[6:2], e[1], e[0]);
      end
    end
  end

  // driver: apply inputs for one MCLK, push expected outputs, advance the model
  task automatic step(input logic r, input logic i);
    logic e_c1, e_c2;
    @(negedge MCLK);
    rst = r;
    ic  = i;
    #1;
    e_c1 = !r && (m_presc == 0);
    e_c2 = !r && (m_presc == DIV / 2);
    exp_q.push_back({e_c1, e_c2, 5'(m_cycle), (m_cycle == 0), (m_state != 0)});
    if (r) begin
      m_presc = 0;
      m_cycle = 0;
      m_state = 1;
    end else begin
      if (e_c1) begin
        if (m_state == 0 && i)       m_state = 1;
        else if (m_state == 1 && !i) m_state = 2;
        else if (m_state == 2) begin
          if (i)                  m_state = 1;
          else if (m_cycle == 23) m_state = 0;
        end
      end
      if (e_c2) m_cycle = (m_state == 1) ? 0 : (m_cycle + 1) % 24;
      m_presc = (m_presc + 1) % DIV;
    end
  endtask

  task automatic test_reset;
    @(posedge MCLK);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({c1, c2, cycle, sync, ic_int} !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL reset_values got c1=%b c2=%b cycle=%0d sync=%b ic_int=%b exp 0 0 0 1 1",
                 c1, c2, cycle, sync, ic_int);
      end
    end
  endtask

  task automatic test_phases;
    for (int k = 0; k < 8 * DIV; k++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({c1, c2} !== {1'(k % DIV == 0), 1'(k % DIV == DIV / 2)}) begin
        errors++;
        $display("FAIL phase_pos k=%0d got c1=%b c2=%b exp c1=%b c2=%b",
                 k, c1, c2, (k % DIV == 0), (k % DIV == DIV / 2));
      end
    end
  endtask

  task automatic test_drain_exit;
    int n = 0;
    int c2n = 0;
    int syncn = 0;
    int hi = 0;
    while (ic_int !== 1'b0 && n < 300) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (ic_int !== 1'b0 || cycle !== 5'd23) begin
      errors++;
      $display("FAIL drain_exit got ic_int=%b cycle=%0d after %0d clocks exp ic_int=0 cycle=23",
               ic_int, cycle, n);
    end
    n = 0;
    while (c2n < 48 && n < 48 * DIV + 10) begin
      step(1'b0, 1'b0);
      n++;
      if (ic_int !== 1'b0) hi++;
      if (c2 === 1'b1) begin
        c2n++;
        if (sync === 1'b1) syncn++;
      end
    end
    checks++;
    if (syncn != 2 || c2n != 48 || hi != 0) begin
      errors++;
      $display("FAIL sync_rate got sync=%0d c2=%0d ic_int_high=%0d exp sync=2 c2=48 ic_int_high=0",
               syncn, c2n, hi);
    end
  endtask

  task automatic test_ic_hold;
    int n = 0;
    while (!(m_cycle == 10 && m_presc == 0) && n < 400) begin
      step(1'b0, 1'b0);
      n++;
    end
    for (int k = 0; k < 2 * DIV; k++) step(1'b0, 1'b1);
    checks++;
    if (cycle !== 5'd0 || ic_int !== 1'b1) begin
      errors++;
      $display("FAIL ic_hold_init got cycle=%0d ic_int=%b exp cycle=0 ic_int=1", cycle, ic_int);
    end
    n = 0;
    while (ic_int !== 1'b0 && n < 400) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (ic_int !== 1'b0 || cycle !== 5'd23) begin
      errors++;
      $display("FAIL ic_hold_release got ic_int=%b cycle=%0d exp ic_int=0 cycle=23", ic_int, cycle);
    end
  endtask

  task automatic test_ic_glitch;
    int n = 0;
    int hi = 0;
    while (m_presc != 1 && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 0; k < 4 * DIV; k++) begin
      step(1'b0, 1'b0);
      if (ic_int !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL ic_glitch got ic_int high for %0d clocks exp 0", hi);
    end
  endtask

  task automatic test_rst_mid;
    int n = 0;
    while (m_presc != 2 && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b1, 1'b0);
    checks++;
    if ({c1, c2} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_hold got c1=%b c2=%b exp 0 0", c1, c2);
    end
    step(1'b0, 1'b0);
    checks++;
    if ({c1, c2, cycle, ic_int} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_release got c1=%b c2=%b cycle=%0d ic_int=%b exp 1 0 0 1",
               c1, c2, cycle, ic_int);
    end
    n = 0;
    while (m_presc != 3 && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b1, 1'b0);
    checks++;
    if (c2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_on_c2 got c2=%b exp 0", c2);
    end
  endtask

  task automatic test_random;
    logic lvl;
    int   hold;
    int   n = 0;
    while (n < 600) begin
      lvl  = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 20);
      for (int k = 0; k < hold; k++) step(1'b0, lvl);
      n += hold;
    end
    for (int k = 0; k < 30 * DIV; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_phases();
    test_drain_exit();
    test_ic_hold();
    test_ic_glitch();
    test_rst_mid();
    test_random();
    @(negedge MCLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
